// File: rtl/multi_meter.sv
// multi_meter: averages 2**AVG_LOG2 lockstep ADC conversions per channel into data_out.
// Define METER_TIMEOUT_EN to add a conversion watchdog that raises a sticky error.
module multi_meter #(
    parameter int NCH         = 2,
    parameter int DW          = 12,
    parameter int AVG_LOG2    = 3,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                continuous,
    output logic                busy,
    output logic [NCH*DW-1:0]   data_out,
    output logic                data_valid,
    output logic                error,
    output logic                adc_start,
    input  logic                adc_new_data,
    input  logic                adc_busy,
    input  logic [NCH*DW-1:0]   adc_data
);
    localparam int AW = DW + AVG_LOG2;
    localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [1:0] IDLE = 2'd0, CONVERT = 2'd1, WAIT_IDLE = 2'd2, ACCUM = 2'd3;

    logic [1:0]                 state;
    logic [CW-1:0]              cnt;
    logic [NCH-1:0][AW-1:0]     acc;
    logic [NCH-1:0][AW-1:0]     sum;
    logic [NCH-1:0][DW-1:0]     sample;
    logic                       last;

    assign busy = state != IDLE;
    assign last = cnt == LAST;

    always_comb begin
        for (int k = 0; k < NCH; k++) sum[k] = acc[k] + AW'(sample[k]);
    end

`ifdef METER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);
    logic [WW-1:0] wd;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_out   <= '0;
            data_valid <= 1'b0;
            adc_start  <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            sample     <= '0;
`ifdef METER_TIMEOUT_EN
            error      <= 1'b0;
            wd         <= '0;
`endif
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    adc_start <= 1'b1;
                    state     <= CONVERT;
`ifdef METER_TIMEOUT_EN
                    error     <= 1'b0;
`endif
                end
                CONVERT: if (adc_new_data) begin
                    sample    <= adc_data;
                    adc_start <= 1'b0;
                    state     <= WAIT_IDLE;
                end
                WAIT_IDLE: if (!adc_busy) state <= ACCUM;
                default: begin
                    if (last) begin
                        for (int k = 0; k < NCH; k++) data_out[k*DW +: DW] <= sum[k][AW-1:AVG_LOG2];
                        data_valid <= 1'b1;
                        acc        <= '0;
                        cnt        <= '0;
                        adc_start  <= continuous;
                        state      <= continuous ? CONVERT : IDLE;
                    end else begin
                        acc       <= sum;
                        cnt       <= cnt + CW'(1);
                        adc_start <= 1'b1;
                        state     <= CONVERT;
                    end
                end
            endcase
`ifdef METER_TIMEOUT_EN
            // every entry to CONVERT comes from IDLE or ACCUM, where the watchdog is held at zero
            if (state == CONVERT || state == WAIT_IDLE) begin
                if (wd == WD_LAST) begin
                    error     <= 1'b1;
                    adc_start <= 1'b0;
                    acc       <= '0;
                    cnt       <= '0;
                    state     <= IDLE;
                end else begin
                    wd <= wd + WW'(1);
                end
            end else begin
                wd <= '0;
            end
`endif
        end
    end
endmodule

// File: doc/multi_meter.md
MULTI_METER -- requirements
Module: multi_meter

Interface
REQ-001 SHALL have parameter NCH, default 2: number of ADC channels converted simultaneously, 1..8.
REQ-002 SHALL have parameter DW, default 12: ADC sample width in bits.
REQ-003 SHALL have parameter AVG_LOG2, default 3: log2 of samples averaged per result, 0..6.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 4095: conversion watchdog limit in clk cycles.
REQ-005 SHALL have port clk  in  1: the single clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-007 SHALL have port start  in  1: request one averaged measurement; sampled in IDLE only.
REQ-008 SHALL have port continuous  in  1: when 1, a new averaging run starts automatically after each result.
REQ-009 SHALL have port busy  out  1: high whenever state is not IDLE.
REQ-010 SHALL have port data_out  out  NCH*DW: averaged results; channel k occupies bits [k*DW +: DW].
REQ-011 SHALL have port data_valid  out  1: one-cycle pulse when data_out updates.
REQ-012 SHALL have port error  out  1: sticky watchdog-timeout flag.
REQ-013 SHALL have port adc_start  out  1: level request to all ADC cores (shared).
REQ-014 SHALL have port adc_new_data  in  1: channel-0 ADC core's result strobe; all cores run in lockstep.
REQ-015 SHALL have port adc_busy  in  1: channel-0 ADC core busy.
REQ-016 SHALL have port adc_data  in  NCH*DW: ADC results, same packing as data_out.

Function
REQ-017 SHALL implement states IDLE, CONVERT, WAIT_IDLE, ACCUM.
REQ-018 IDLE: adc_start=0; start=1 -> adc_start=1 next cycle, go CONVERT.
REQ-019 CONVERT: adc_new_data=1 -> capture all NCH samples of adc_data, adc_start=0, go WAIT_IDLE.
REQ-020 WAIT_IDLE: adc_busy=0 -> go ACCUM; otherwise remain.
REQ-021 ACCUM (one cycle): add each captured sample to its per-channel accumulator of width DW+AVG_LOG2 (never overflows), increment sample counter.
REQ-022 Exactly 2**AVG_LOG2 samples SHALL be summed per result; the final sample SHALL be included.
REQ-023 On the final sample: data_out[k] = (acc[k]+sample[k]) >> AVG_LOG2 (truncating); data_valid=1 for that one cycle; accumulators and counter cleared.
REQ-024 After the final sample: continuous=1 -> adc_start=1, go CONVERT; continuous=0 -> go IDLE.
REQ-025 After a non-final sample: adc_start=1, go CONVERT.
REQ-026 AVG_LOG2=0 SHALL give data_out equal to each single sample.
REQ-027 start while busy SHALL be ignored and not queued.
REQ-028 continuous deasserted mid-run SHALL let the current run finish, then go IDLE.
REQ-029 data_out SHALL hold its value between data_valid pulses.

Reset
REQ-030 On rst=1 at a clk edge, the block SHALL enter IDLE and clear data_out, data_valid, adc_start, error, accumulators, counters and captured samples.
REQ-031 Reset mid-run SHALL discard partial accumulation; no data_valid SHALL follow.

Configuration
REQ-032 Macro METER_TIMEOUT_EN defined: a cycle counter SHALL run in CONVERT and WAIT_IDLE.
- It SHALL reset on each entry to CONVERT.
- Reaching TIMEOUT_CYC: set error, adc_start=0, clear accumulators and counter, go IDLE, no data_valid.
- error SHALL clear on rst or on the next accepted start.
REQ-033 Macro undefined: no watchdog logic; error tied 0; a stalled ADC holds CONVERT indefinitely.

Verification (NCH=2, DW=12, AVG_LOG2=3)
REQ-034 ch0=0x800, ch1=0x123 on every conversion, one start -> 8 adc_start pulses, one data_valid, data_out={0x123,0x800}, busy returns to 0.
REQ-035 ch0 samples 0..7 in sequence -> ch0 result 0x003 (28>>3); ch1=0xFFF x8 -> result 0xFFF, no overflow.
REQ-036 continuous=1 for 20 conversions then 0 -> data_valid after conversions 8, 16, 24; IDLE after 24.
REQ-037 METER_TIMEOUT_EN, TIMEOUT_CYC=100, adc_new_data held 0 -> error=1 within 100 cycles of CONVERT entry, busy=0, no data_valid; next start clears error.
REQ-038 rst pulsed after 4 conversions, then one start with constant 0x010 -> result 0x010 (no stale contribution); start during busy ignored.
